counter_bcd_multi: RTL
======================

# counter_bcd_multi

Parametrised multi-digit BCD counter. Successor to the single-digit BCD counter, for use in display and timer labs. Counts a configurable number of decimal digits as one synchronous unit, with:
- count-enable;
- optional up/down direction;
- synchronous parallel load with digit validation;
- combinational terminal-count output for cascading;
- sticky wrap flag.

Feeds the 7-segment display multiplexer and seconds/minutes timer chains.

## Interface

Parameters:
- `NDIGITS`, default 4: number of BCD digits, legal range 1 to 8.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable, sampled on the `clk` rising edge.
- `up`  in  1  direction: 1 = increment, 0 = decrement. Only used when `BCD_DOWN_COUNT_EN` is defined.
- `load`  in  1  synchronous parallel load of `din`.
- `din`  in  4*NDIGITS  load value. Digit k occupies bits [4k+3:4k]; digit 0 is least significant.
- `bcd`  out  4*NDIGITS  registered count value, same digit packing as `din`.
- `tc`  out  1  combinational terminal count, for cascading into the next counter's `en`.
- `wrap`  out  1  sticky flag, set when the counter rolls over.
- `load_err`  out  1  registered, one-cycle pulse flagging an invalid load digit.

## Operation

- Priority on each rising edge of `clk`: `rst`, then `load`, then `en`. Otherwise all registers hold.
- Reset values: `bcd` = all zeros, `wrap` = 0, `load_err` = 0.
- Load:
  - `bcd` <= `din`, digit by digit. Any digit greater than 9 is stored as 0.
  - `load_err` = 1 on the next cycle if any `din` digit is greater than 9, else 0.
  - `wrap` is cleared.
  - `en` is ignored during a load cycle.
- Count up (`en`=1, direction up):
  - Digit 0 increments.
  - Digit k (k>0) changes only when all lower digits equal 9. It then increments; 9 rolls to 0.
  - All digits equal to 9 rolls to all zeros, and `wrap` is set.
- Count down (`en`=1, `up`=0, macro defined):
  - Digit 0 decrements.
  - Digit k (k>0) changes only when all lower digits equal 0. It then decrements; 0 rolls to 9.
  - All digits equal to 0 rolls to all 9s, and `wrap` is set.
- `tc` = `en` AND (up: all digits equal 9; down: all digits equal 0). `tc` is purely combinational and has no extra latency.
- `wrap` remains set until `rst` or `load`. A new wrap while `wrap` is already set has no further effect.
- `load_err` is 0 in every cycle not immediately following a load.
- Illegal state: a digit above 9 can never be produced by counting or loading. The bench asserts this every cycle.

## Timing

- `bcd` updates one clock after the qualifying edge (register latency of 1).
- `tc` is valid in the same cycle as `bcd` and `en`. Chaining rule: counter B's `en` = counter A's `tc`. B then advances on the same edge that A wraps.
- `wrap` and `load_err` are valid from the edge after the triggering event.
- Reset mid-count: the counter is all zeros on the next edge, whatever `load` and `en` are. `tc` then equals `en` AND down-mode.
- Direction change (`up` toggled while `en`=1) takes effect on the next edge, with no dead cycle.

## Configuration

- Macro `BCD_DOWN_COUNT_EN`.
- Defined: up/down counting as above, and `up` is decoded.
- Undefined:
  - The `up` port remains but is ignored.
  - The counter counts up only.
  - `tc` = `en` AND all digits equal 9.
  - No down-count logic is synthesised.

## Test plan

All scenarios use `NDIGITS`=3 unless stated.

1. Reset and hold: assert `rst` for 2 cycles, then `en`=0 for 5 cycles -> `bcd`=000 throughout; `wrap`=0; `load_err`=0.
2. Up-count carry ripple:
   - Load 098, then `en`=1 for 3 cycles -> `bcd` sequence 099, 100, 101.
   - `tc` stays 0.
   - Load 998, `en`=1 for 3 cycles -> `bcd` sequence 999 (with `tc`=1 in that cycle), then 000 (with `wrap`=1), then 001.
3. Down-count borrow, macro defined: load 001, `up`=0, `en`=1 for 3 cycles -> `bcd` sequence 000 (with `tc`=1 in that cycle), then 999 (with `wrap`=1), then 998.
4. Invalid load: `din` = digits {A,5,F} -> `bcd`=050; `load_err`=1 for exactly one cycle; `wrap` cleared.
5. Priority: `rst`=1, `load`=1, `en`=1 on the same edge -> `bcd`=000. Then `load`=1 with `en`=1 and `din`=123 -> `bcd`=123, not 124.
6. Cascade: two instances, each `NDIGITS`=1, the second's `en` driven by the first's `tc`. Apply 25 enabled cycles from reset -> combined value is 25, and the second instance advances on the edges where the first goes 9 -> 0.

Source files
------------

// File: rtl/counter_bcd_multi.sv
// Multi-digit synchronous BCD counter with load, terminal count and sticky wrap.
// Define BCD_DOWN_COUNT_EN to build the up/down variant; otherwise it counts up only.
module counter_bcd_multi #(
   parameter int NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   up,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   din,
   output logic [4*NDIGITS-1:0]   bcd,
   output logic                   tc,
   output logic                   wrap,
   output logic                   load_err
);

   localparam int W = 4 * NDIGITS;

   logic [W-1:0] nxt;
   logic [W-1:0] din_ok;
   logic [3:0]   dig;
   logic         carry;
   logic         all9;
   logic         term;
   logic         bad;

   always_comb begin
      all9   = 1'b1;
      bad    = 1'b0;
      din_ok = '0;
      for (int k = 0; k < NDIGITS; k++) begin
         all9 &= (bcd[4*k +: 4] == 4'd9);
         if (din[4*k +: 4] > 4'd9)
            bad = 1'b1;
         else
            din_ok[4*k +: 4] = din[4*k +: 4];
      end
   end

`ifdef BCD_DOWN_COUNT_EN
   logic all0;
   logic dn;

   assign dn = ~up;

   always_comb begin
      all0 = 1'b1;
      for (int k = 0; k < NDIGITS; k++)
         all0 &= (bcd[4*k +: 4] == 4'd0);
   end

   assign term = dn ? all0 : all9;
`else
   logic unused_up;

   assign unused_up = up;
   assign term      = all9;
`endif

   // Ripple carry/borrow: a digit moves only while every lower digit is at its limit
   always_comb begin
      nxt   = bcd;
      carry = 1'b1;
      dig   = 4'd0;
      for (int k = 0; k < NDIGITS; k++) begin
         dig = bcd[4*k +: 4];
         if (carry) begin
`ifdef BCD_DOWN_COUNT_EN
            if (dn) begin
               nxt[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
               carry         = (dig == 4'd0);
            end else
`endif
            begin
               nxt[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
               carry         = (dig == 4'd9);
            end
         end
      end
   end

   assign tc = en & term;

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd      <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         bcd      <= din_ok;
         wrap     <= 1'b0;
         load_err <= bad;
      end else begin
         load_err <= 1'b0;
         if (en) begin
            bcd <= nxt;
            if (term)
               wrap <= 1'b1;
         end
      end
   end

endmodule
